// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for the multi-channel debouncer
//
// Purpose : default timing constants for a 50 MHz system clock and the
//           counter-width helper used by every debounce counter.
// Ports   : none (package).
`timescale 1ns/1ps
package debounce_pkg;

   localparam int CLK_HZ        = 50000000;
   localparam int DEBOUNCE_50US = CLK_HZ / 20000;
   localparam int LONG_1S       = CLK_HZ;

   // Width able to hold the value n itself, not just n-1.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced channel with press/release/long-press pulses
//
// Purpose : saturating stability counter, accept logic, edge pulses and the
//           optional hold counter for a single synchronised, logical input.
// Ports   : clk              - system clock
//           rst_n            - asynchronous active-low reset
//           s                - synchronised logical input, 1 = pressed
//           button_state     - accepted level
//           press_pulse      - one cycle on accepted 0->1
//           release_pulse    - one cycle on accepted 1->0
//           long_press_pulse - one cycle LONG_COUNTS cycles after press_pulse
// Macro   : DEBOUNCE_LONG_PRESS_EN enables the hold counter; otherwise
//           long_press_pulse is tied low.
`timescale 1ns/1ps
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DELAY_COUNTS = DEBOUNCE_50US,
   parameter int LONG_COUNTS  = LONG_1S
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   output logic button_state,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse
);

   localparam int            CW        = cnt_width(DELAY_COUNTS);
   localparam logic [CW-1:0] DELAY_MAX = CW'(DELAY_COUNTS);

   if (DELAY_COUNTS < 1 || LONG_COUNTS < 1) begin : g_bad_param
      $error("debounce_channel: DELAY_COUNTS and LONG_COUNTS must be >= 1");
   end

   logic          prev;
   logic [CW-1:0] count;
   logic          accept;

   // prev has been stable for DELAY_COUNTS+1 samples and differs from
   // what is already reported.
   assign accept = (s == prev) && (count == DELAY_MAX) && (button_state != prev);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev          <= 1'b0;
         count         <= '0;
         button_state  <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         if (s != prev) begin
            prev  <= s;
            count <= '0;
         end else if (count != DELAY_MAX) begin
            count <= count + CW'(1);
         end
         press_pulse   <= accept & prev;
         release_pulse <= accept & ~prev;
         if (accept) begin
            button_state <= prev;
         end
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int            HW       = cnt_width(LONG_COUNTS);
   localparam logic [HW-1:0] LONG_MAX = HW'(LONG_COUNTS);
   localparam logic [HW-1:0] LONG_HIT = HW'(LONG_COUNTS - 1);

   logic [HW-1:0] hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (!button_state || press_pulse) begin
         hold <= '0;
      end else if (hold != LONG_MAX) begin
         hold <= hold + HW'(1);
      end
   end

   // hold reads k-1 in the k-th cycle after press_pulse; saturating at
   // LONG_COUNTS means LONG_HIT is passed only once per press.
   assign long_press_pulse = button_state && !press_pulse && (hold == LONG_HIT);
`else
   assign long_press_pulse = 1'b0;
`endif

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two flip-flop synchroniser for one asynchronous bit
//
// Purpose : brings an asynchronous pin into the clk domain.
// Ports   : clk       - system clock
//           rst_n     - asynchronous active-low reset
//           d         - raw asynchronous input
//           q         - synchronised output (two cycles of latency)
// RESET_VAL lets the caller preload the pin's idle level so that the
// synchroniser does not present a fake edge when reset is released.
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - parametrised multi-channel push-button/switch debouncer
//
// Purpose : synchronises each raw pin, normalises it to 1 = pressed and
//           debounces it in an independent debounce_channel.
// Ports   : clk              - 50 MHz system clock
//           rst_n            - asynchronous active-low reset
//           button           - raw asynchronous pins [NUM_CH]
//           button_state     - debounced level, 1 = pressed [NUM_CH]
//           press_pulse      - one-cycle accepted press [NUM_CH]
//           release_pulse    - one-cycle accepted release [NUM_CH]
//           long_press_pulse - one-cycle sustained press [NUM_CH]
// Macro   : DEBOUNCE_LONG_PRESS_EN enables long-press detection.
`timescale 1ns/1ps
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DELAY_COUNTS = DEBOUNCE_50US,
   parameter int ACTIVE_LOW   = 1,
   parameter int LONG_COUNTS  = LONG_1S
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] button,
   output logic [NUM_CH-1:0] button_state,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic [NUM_CH-1:0] long_press_pulse
);

   // Preload the synchroniser with the released pin level so reset
   // release never looks like an edge.
   localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0] s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_2ff #(
         .RESET_VAL (PIN_IDLE)
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (button[i]),
         .q     (sync_q[i])
      );

      assign s[i] = (ACTIVE_LOW != 0) ? ~sync_q[i] : sync_q[i];

      debounce_channel #(
         .DELAY_COUNTS (DELAY_COUNTS),
         .LONG_COUNTS  (LONG_COUNTS)
      ) u_chan (
         .clk              (clk),
         .rst_n            (rst_n),
         .s                (s[i]),
         .button_state     (button_state[i]),
         .press_pulse      (press_pulse[i]),
         .release_pulse    (release_pulse[i]),
         .long_press_pulse (long_press_pulse[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi
`timescale 1ns/1ps
module tb_debounce_multi;

   localparam int NCH = 2;
   localparam int D   = 4;
   localparam int L   = 10;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_LONG    = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] button = '1;
   logic [NCH-1:0] button_state;
   logic [NCH-1:0] press_pulse;
   logic [NCH-1:0] release_pulse;
   logic [NCH-1:0] long_press_pulse;

   always #10 clk = ~clk;

   debounce_multi #(
      .NUM_CH       (NCH),
      .DELAY_COUNTS (D),
      .ACTIVE_LOW   (1),
      .LONG_COUNTS  (L)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .button           (button),
      .button_state     (button_state),
      .press_pulse      (press_pulse),
      .release_pulse    (release_pulse),
      .long_press_pulse (long_press_pulse)
   );

   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   ev_t expq[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;

   // Reference model: a level is accepted once the logical pin has been
   // sampled at that level on D+2 consecutive edges; the result shows up
   // two edges later. Long press follows the press by L cycles unless the
   // release is shown first.
   int run  [NCH];
   bit last [NCH];
   bit acc  [NCH];
   bit shown[NCH];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         expq.delete();
         for (int c = 0; c < NCH; c++) begin
            run[c]  = 0;
            last[c] = 1'b0;
            acc[c]  = 1'b0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            bit p;
            p = ~button[c];
            if (p == last[c]) begin
               if (run[c] < 1000) run[c] = run[c] + 1;
            end else begin
               run[c]  = 1;
               last[c] = p;
            end
            if (run[c] >= D + 2 && acc[c] != p) begin
               acc[c] = p;
               if (p) begin
                  expq.push_back('{cyc + 2, c, K_PRESS});
`ifdef DEBOUNCE_LONG_PRESS_EN
                  expq.push_back('{cyc + 2 + L, c, K_LONG});
`endif
               end else begin
                  expq.push_back('{cyc + 2, c, K_RELEASE});
                  for (int i = expq.size() - 1; i >= 0; i--)
                     if (expq[i].ch == c && expq[i].kind == K_LONG && expq[i].cyc >= cyc + 2)
                        expq.delete(i);
               end
            end
         end
      end
   end

   function automatic string kname(input int k);
      return (k == K_PRESS) ? "press_pulse" : (k == K_RELEASE) ? "release_pulse" : "long_press_pulse";
   endfunction

   // Monitor: pops expected events whenever the DUT is due to present them.
   always begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < 3; k++) begin
            bit e;
            bit a;
            e = 1'b0;
            for (int i = expq.size() - 1; i >= 0; i--) begin
               if (expq[i].cyc == cyc && expq[i].ch == c && expq[i].kind == k) begin
                  e = 1'b1;
                  expq.delete(i);
               end
            end
            a = (k == K_PRESS) ? press_pulse[c] : (k == K_RELEASE) ? release_pulse[c] : long_press_pulse[c];
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL %s ch%0d cyc=%0d got=%0b exp=%0b", kname(k), c, cyc, a, e);
            end
            if (e && k == K_PRESS)   shown[c] = 1'b1;
            if (e && k == K_RELEASE) shown[c] = 1'b0;
         end
         if (!rst_n) shown[c] = 1'b0;
         checks++;
         if (button_state[c] !== shown[c]) begin
            failures++;
            $display("FAIL button_state ch%0d cyc=%0d got=%0b exp=%0b", c, cyc, button_state[c], shown[c]);
         end
      end
      for (int i = expq.size() - 1; i >= 0; i--) begin
         if (expq[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_%s ch%0d due=%0d got=none exp=pulse", kname(expq[i].kind), expq[i].ch, expq[i].cyc);
            expq.delete(i);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_state"},   8'(button_state),     8'h00);
      chk({name, "_press"},   8'(press_pulse),      8'h00);
      chk({name, "_release"}, 8'(release_pulse),    8'h00);
      chk({name, "_long"},    8'(long_press_pulse), 8'h00);
   endtask

   initial begin
      // Both pins pressed through reset.
      rst_n  = 1'b0;
      button = 2'b00;
      idle(3);
      rst_n = 1'b1;
      #1 chk_all_zero("reset_release");
      idle(15);
      chk("held_through_reset_state", 8'(button_state), 8'h03);

      button = 2'b11;
      idle(12);

      // Clean press and release on ch0.
      button[0] = 1'b0;
      idle(12);
      button[0] = 1'b1;
      idle(12);

      // Short glitch, then bounce train settling low.
      button[0] = 1'b0;
      idle(3);
      button[0] = 1'b1;
      idle(12);
      for (int k = 0; k < 5; k++) begin
         button[0] = ~button[0];
         idle(2);
      end
      idle(12);

      // Release ch0 and press ch1 on the same edge.
      button = 2'b01;
      idle(12);
      button = 2'b11;
      idle(12);

      // Long hold, then a hold released well before the long point.
      button[0] = 1'b0;
      idle(30);
      button[0] = 1'b1;
      idle(12);
      button[0] = 1'b0;
      idle(6);
      button[0] = 1'b1;
      idle(15);

      // Reset in the middle of a debounce while ch1 is reported pressed.
      button[1] = 1'b0;
      idle(12);
      button[0] = 1'b0;
      idle(5);
      rst_n = 1'b0;
      #1 chk_all_zero("mid_reset");
      idle(3);
      rst_n = 1'b1;
      idle(20);
      chk("redebounce_state", 8'(button_state), 8'h03);

      // Random pin activity, including glitches.
      repeat (150) begin
         button = 2'($urandom);
         idle($urandom_range(1, 14));
      end
      button = 2'b11;
      idle(30);

      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL leftover_events got=%0d exp=0", expq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
